lat_test_ctrl: RTL and testbench

LAT_TEST_CTRL -- requirements
Module: lat_test_ctrl

---
 rtl/lat_test_ctrl_pkg.sv | 23 ++
 rtl/lat_test_ctrl_sync.sv | 31 +++
 rtl/lat_test_ctrl.sv | 122 ++++++++++++
 tb/tb_lat_test_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/lat_test_ctrl_pkg.sv
// rtl/lat_test_ctrl_pkg.sv - shared lat_tester definitions: FSM states, timebase default, box positions
package lat_test_ctrl_pkg;

   localparam int LT_PRESCALE_DEF = 27;

   localparam logic [1:0] LT_POS_CENTER = 2'b00;
   localparam logic [1:0] LT_POS_TOP    = 2'b01;
   localparam logic [1:0] LT_POS_BOTTOM = 2'b10;
   localparam logic [1:0] LT_POS_CORNER = 2'b11;

   typedef enum logic [2:0] {
      LT_IDLE = 3'd0,
      LT_ARM  = 3'd1,
      LT_LAT  = 3'd2,
      LT_STB  = 3'd3,
      LT_DONE = 3'd4
   } lt_state_e;

   function automatic logic [15:0] lt_sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/lat_test_ctrl_sync.sv
// rtl/lat_test_ctrl_sync.sv - photodiode synchroniser and vsync falling-edge detector
module lt_sync #(
   parameter int STAGES = 2
) (
   input  logic clk27,
   input  logic reset_n,
   input  logic sensor_n,
   input  logic VSYNC_in,
   output logic light,
   output logic vs_fall
);

   logic [STAGES-1:0] sens_q;
   logic              vs_q;

   // Flops reset to 1 so a fresh reset reads as dark with vsync inactive.
   always_ff @(posedge clk27 or negedge reset_n) begin
      if (!reset_n) begin
         sens_q <= '1;
         vs_q   <= 1'b1;
      end else begin
         sens_q[0] <= sensor_n;
         for (int i = 1; i < STAGES; i++) sens_q[i] <= sens_q[i-1];
         vs_q <= VSYNC_in;
      end
   end

   assign light   = ~sens_q[STAGES-1];
   assign vs_fall = vs_q & ~VSYNC_in;

endmodule

// File: rtl/lat_test_ctrl.sv
// rtl/lat_test_ctrl.sv - display latency tester: arms on vsync, times light-on latency and duration in us
module lat_test_ctrl
   import lat_test_ctrl_pkg::*;
#(
   parameter int PRESCALE    = LT_PRESCALE_DEF,
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk27,
   input  logic        reset_n,
   input  logic        start,
   input  logic        abort,
   input  logic [1:0]  mode_sel,
   input  logic        VSYNC_in,
   input  logic        sensor_n,
   output logic        lt_active,
   output logic [1:0]  lt_mode,
   output logic [15:0] lat_us,
   output logic [15:0] stb_us,
   output logic        busy,
   output logic        done,
   output logic        timeout
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

   lt_state_e     state_q, state_d;
   logic [PW-1:0] presc_q;
   logic          light, vs_fall;
   logic          tick, lat_sat, stb_sat;

   lt_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk27    (clk27),
      .reset_n  (reset_n),
      .sensor_n (sensor_n),
      .VSYNC_in (VSYNC_in),
      .light    (light),
      .vs_fall  (vs_fall)
   );

   always_ff @(posedge clk27 or negedge reset_n) begin
      if (!reset_n) state_q <= LT_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      tick    = (presc_q == PRE_MAX);
      // Saturation is the tick that would carry the counter onto FFFF.
      lat_sat = tick && (lat_us >= 16'hFFFE);
      stb_sat = tick && (stb_us >= 16'hFFFE);
      case (state_q)
         LT_IDLE: if (start) state_d = LT_ARM;
         LT_ARM:  if (vs_fall && !light) state_d = LT_LAT;
         LT_LAT: begin
            if (light)        state_d = LT_STB;
            else if (lat_sat) state_d = LT_DONE;
         end
         LT_STB:  if (!light || stb_sat) state_d = LT_DONE;
         LT_DONE: state_d = LT_IDLE;
         default: state_d = LT_IDLE;
      endcase
      if (abort) state_d = LT_IDLE;
   end

   always_ff @(posedge clk27 or negedge reset_n) begin
      if (!reset_n) begin
         lt_active <= 1'b0;
         lt_mode   <= 2'b00;
         lat_us    <= 16'd0;
         stb_us    <= 16'd0;
         timeout   <= 1'b0;
         presc_q   <= '0;
      end else if (abort) begin
         lt_active <= 1'b0;
      end else begin
         case (state_q)
            LT_IDLE: begin
               if (start) begin
                  lt_mode <= mode_sel;
                  lat_us  <= 16'd0;
                  stb_us  <= 16'd0;
                  timeout <= 1'b0;
                  presc_q <= '0;
               end
            end
            LT_ARM: begin
               if (state_d == LT_LAT) begin
                  lt_active <= 1'b1;
                  presc_q   <= '0;
                  lat_us    <= 16'd0;
               end
            end
            LT_LAT: begin
               if (light) begin
                  presc_q <= '0;
               end else begin
                  presc_q <= tick ? '0 : presc_q + 1'b1;
                  if (tick) lat_us <= lt_sat_inc(lat_us);
                  if (lat_sat) begin
                     timeout   <= 1'b1;
                     lt_active <= 1'b0;
                  end
               end
            end
            LT_STB: begin
               presc_q <= tick ? '0 : presc_q + 1'b1;
               if (light) begin
                  if (tick)    stb_us  <= lt_sat_inc(stb_us);
                  if (stb_sat) timeout <= 1'b1;
               end
               if (state_d == LT_DONE) lt_active <= 1'b0;
            end
            default: lt_active <= 1'b0;
         endcase
      end
   end

   assign busy = (state_q != LT_IDLE);
   assign done = (state_q == LT_DONE);

endmodule

// File: tb/tb_lat_test_ctrl.sv
// tb/tb_lat_test_ctrl.sv - randomized self-checking bench for lat_test_ctrl
module tb_lat_test_ctrl;
   import lat_test_ctrl_pkg::*;

   localparam int P = 27;

   logic clk27 = 1'b0;
   logic reset_n, start, abort, VSYNC_in, sensor_n;
   logic [1:0] mode_sel;
   logic lt_active, busy, done, timeout;
   logic [1:0] lt_mode;
   logic [15:0] lat_us, stb_us;
   logic f_lt_active, f_busy, f_done, f_timeout;
   logic [1:0] f_lt_mode;
   logic [15:0] f_lat_us, f_stb_us;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   int f_done_cnt = 0;

   always #5 clk27 = ~clk27;

   lat_test_ctrl #(.PRESCALE(P), .SYNC_STAGES(2)) dut (
      .clk27(clk27), .reset_n(reset_n), .start(start), .abort(abort),
      .mode_sel(mode_sel), .VSYNC_in(VSYNC_in), .sensor_n(sensor_n),
      .lt_active(lt_active), .lt_mode(lt_mode), .lat_us(lat_us), .stb_us(stb_us),
      .busy(busy), .done(done), .timeout(timeout)
   );

   lat_test_ctrl #(.PRESCALE(1), .SYNC_STAGES(2)) dut_fast (
      .clk27(clk27), .reset_n(reset_n), .start(start), .abort(abort),
      .mode_sel(mode_sel), .VSYNC_in(VSYNC_in), .sensor_n(sensor_n),
      .lt_active(f_lt_active), .lt_mode(f_lt_mode), .lat_us(f_lat_us), .stb_us(f_stb_us),
      .busy(f_busy), .done(f_done), .timeout(f_timeout)
   );

   always @(negedge clk27) begin
      if (done === 1'b1) done_cnt++;
      if (f_done === 1'b1) f_done_cnt++;
   end

   task automatic pulse_vsync();
      @(negedge clk27) VSYNC_in = 1'b0;
      @(negedge clk27) VSYNC_in = 1'b1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; start = 0; abort = 0; mode_sel = 2'b00; VSYNC_in = 1; sensor_n = 1;
      repeat (3) @(negedge clk27);
      checks++; if ({lt_active, busy, done, timeout} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {lt_active, busy, done, timeout}); end
      checks++; if (lt_mode !== 2'b00) begin errors++; $display("FAIL reset_mode: got %0d expected 0", lt_mode); end
      checks++; if (lat_us !== 16'd0 || stb_us !== 16'd0) begin errors++; $display("FAIL reset_results: got %0d/%0d expected 0/0", lat_us, stb_us); end
      reset_n = 1'b1;
      @(negedge clk27);
   endtask

   task automatic measure(input logic [1:0] mode, input int lat_cyc, input int stb_cyc);
      int d0, el, es;
      el = lat_cyc / P;
      es = stb_cyc / P;
      @(negedge clk27) begin start = 1; mode_sel = mode; end
      @(negedge clk27) begin start = 0; mode_sel = ~mode; end
      checks++; if (busy !== 1'b1 || lt_active !== 1'b0) begin errors++; $display("FAIL arm_state: got busy=%b act=%b expected 1/0", busy, lt_active); end
      checks++; if (lat_us !== 16'd0) begin errors++; $display("FAIL start_clear: got %0d expected 0", lat_us); end
      repeat (3) @(negedge clk27);
      VSYNC_in = 1'b0;
      @(negedge clk27);
      checks++; if (lt_active !== 1'b1) begin errors++; $display("FAIL lat_entry: got act=%b expected 1", lt_active); end
      VSYNC_in = 1'b1;
      d0 = done_cnt;
      repeat (lat_cyc - 1) @(negedge clk27);
      sensor_n = 1'b0;
      repeat (stb_cyc) @(negedge clk27);
      sensor_n = 1'b1;
      repeat (8) @(negedge clk27);
      checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL done_pulses: got %0d expected 1", done_cnt - d0); end
      checks++; if (int'(lat_us) < el - 1 || int'(lat_us) > el + 1) begin errors++; $display("FAIL lat_us: got %0d expected %0d+-1", lat_us, el); end
      checks++; if (int'(stb_us) < es - 1 || int'(stb_us) > es + 1) begin errors++; $display("FAIL stb_us: got %0d expected %0d+-1", stb_us, es); end
      checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL meas_timeout: got %b expected 0", timeout); end
      checks++; if (lt_mode !== mode) begin errors++; $display("FAIL lt_mode: got %0d expected %0d", lt_mode, mode); end
      checks++; if (lt_active !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL meas_end: got act=%b busy=%b expected 0/0", lt_active, busy); end
   endtask

   task automatic test_directed();
      measure(LT_POS_CENTER, 2700, 540);
   endtask

   task automatic test_random();
      for (int n = 0; n < 4; n++)
         measure(2'($urandom_range(0, 3)), $urandom_range(60, 1500), $urandom_range(60, 800));
   endtask

   task automatic test_arm_hold();
      @(negedge clk27) start = 1;
      @(negedge clk27) start = 0;
      sensor_n = 1'b0;
      repeat (4) @(negedge clk27);
      for (int k = 0; k < 3; k++) begin
         pulse_vsync();
         @(negedge clk27);
         checks++; if (lt_active !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL arm_hold_%0d: got act=%b busy=%b expected 0/1", k, lt_active, busy); end
      end
      sensor_n = 1'b1;
      repeat (4) @(negedge clk27);
      checks++; if (lt_active !== 1'b0) begin errors++; $display("FAIL arm_release: got act=%b expected 0", lt_active); end
      pulse_vsync();
      checks++; if (lt_active !== 1'b1) begin errors++; $display("FAIL arm_next_vs: got act=%b expected 1", lt_active); end
      @(negedge clk27) abort = 1;
      @(negedge clk27) abort = 0;
      checks++; if (busy !== 1'b0 || lt_active !== 1'b0) begin errors++; $display("FAIL arm_abort: got busy=%b act=%b expected 0/0", busy, lt_active); end
   endtask

   task automatic test_abort_lat();
      int w, el, d0;
      w = $urandom_range(200, 1500);
      el = w / P;
      @(negedge clk27) start = 1;
      @(negedge clk27) start = 0;
      repeat (2) @(negedge clk27);
      pulse_vsync();
      d0 = done_cnt;
      repeat (w - 1) @(negedge clk27);
      abort = 1'b1;
      @(negedge clk27) abort = 1'b0;
      checks++; if (busy !== 1'b0 || lt_active !== 1'b0) begin errors++; $display("FAIL abort_state: got busy=%b act=%b expected 0/0", busy, lt_active); end
      repeat (20) @(negedge clk27);
      checks++; if (done_cnt != d0) begin errors++; $display("FAIL abort_done: got %0d pulses expected 0", done_cnt - d0); end
      checks++; if (int'(lat_us) < el - 1 || int'(lat_us) > el + 1) begin errors++; $display("FAIL abort_lat: got %0d expected %0d+-1", lat_us, el); end
      checks++; if (stb_us !== 16'd0 || timeout !== 1'b0) begin errors++; $display("FAIL abort_results: got stb=%0d to=%b expected 0/0", stb_us, timeout); end
   endtask

   task automatic test_start_busy();
      int d0;
      @(negedge clk27) begin start = 1; mode_sel = LT_POS_CENTER; end
      @(negedge clk27) start = 0;
      repeat (2) @(negedge clk27);
      pulse_vsync();
      @(negedge clk27) begin start = 1; mode_sel = LT_POS_CORNER; end
      @(negedge clk27) start = 0;
      checks++; if (lt_mode !== LT_POS_CENTER || busy !== 1'b1 || lt_active !== 1'b1) begin errors++; $display("FAIL start_busy: got mode=%0d busy=%b act=%b expected 0/1/1", lt_mode, busy, lt_active); end
      @(negedge clk27) abort = 1;
      @(negedge clk27) abort = 0;
      d0 = done_cnt;
      @(negedge clk27) begin start = 1; abort = 1; mode_sel = LT_POS_TOP; end
      @(negedge clk27) begin start = 0; abort = 0; end
      checks++; if (busy !== 1'b0 || lt_mode !== LT_POS_CENTER) begin errors++; $display("FAIL start_abort: got busy=%b mode=%0d expected 0/0", busy, lt_mode); end
      repeat (5) @(negedge clk27);
      checks++; if (busy !== 1'b0 || done_cnt != d0) begin errors++; $display("FAIL start_abort_idle: got busy=%b pulses=%0d expected 0/0", busy, done_cnt - d0); end
   endtask

   task automatic test_reset_mid_stb();
      int d0;
      @(negedge clk27) begin start = 1; mode_sel = LT_POS_BOTTOM; end
      @(negedge clk27) start = 0;
      repeat (2) @(negedge clk27);
      pulse_vsync();
      repeat (60) @(negedge clk27);
      sensor_n = 1'b0;
      repeat (100) @(negedge clk27);
      d0 = done_cnt;
      #2 reset_n = 1'b0;
      #1;
      checks++; if ({lt_active, busy, done, timeout} !== 4'b0000 || lt_mode !== 2'b00) begin errors++; $display("FAIL rst_stb_flags: got %b mode=%0d expected 0000/0", {lt_active, busy, done, timeout}, lt_mode); end
      checks++; if (lat_us !== 16'd0 || stb_us !== 16'd0) begin errors++; $display("FAIL rst_stb_results: got %0d/%0d expected 0/0", lat_us, stb_us); end
      @(negedge clk27) begin reset_n = 1'b1; sensor_n = 1'b1; end
      repeat (40) @(negedge clk27);
      checks++; if (done_cnt != d0 || busy !== 1'b0) begin errors++; $display("FAIL rst_stb_after: got pulses=%0d busy=%b expected 0/0", done_cnt - d0, busy); end
   endtask

   task automatic test_timeout();
      int d0;
      bit got;
      got = 0;
      @(negedge clk27) begin start = 1; mode_sel = 2'($urandom_range(0, 3)); end
      @(negedge clk27) start = 0;
      repeat (2) @(negedge clk27);
      d0 = f_done_cnt;
      pulse_vsync();
      for (int i = 0; i < 70000 && !got; i++) begin
         @(negedge clk27);
         if (f_done === 1'b1) got = 1;
      end
      checks++; if (!got) begin errors++; $display("FAIL timeout_wait: got no done expected done within 70000 cycles"); end
      repeat (3) @(negedge clk27);
      checks++; if (f_lat_us !== 16'hFFFF) begin errors++; $display("FAIL timeout_lat: got %h expected ffff", f_lat_us); end
      checks++; if (f_timeout !== 1'b1 || f_lt_active !== 1'b0 || f_busy !== 1'b0) begin errors++; $display("FAIL timeout_flags: got to=%b act=%b busy=%b expected 1/0/0", f_timeout, f_lt_active, f_busy); end
      checks++; if (f_done_cnt - d0 != 1) begin errors++; $display("FAIL timeout_done: got %0d pulses expected 1", f_done_cnt - d0); end
      @(negedge clk27) abort = 1;
      @(negedge clk27) abort = 0;
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_arm_hold();
      test_abort_lat();
      test_start_busy();
      test_reset_mid_stb();
      test_timeout();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
